cp0_reg: RTL
============

CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 Parameter COUNT_HALF, default 1, meaning Count increments every 2nd cycle when 1 and every cycle when 0.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 we_i  input  1  MTC0 write enable.
REQ-005 waddr_i  input  5  MTC0 destination register number.
REQ-006 raddr_i  input  5  MFC0 source register number.
REQ-007 data_i  input  32  MTC0 write data.
REQ-008 int_i  input  6  external hardware interrupt lines, level-sensitive.
REQ-009 excepttype_i  input  32  exception code from the exception-judge stage (0 = none, 1/4/5/8/9/a/c = exception, e = eret).
REQ-010 current_inst_addr_i  input  32  PC of the excepting instruction.
REQ-011 is_in_delayslot_i  input  1  excepting instruction sits in a branch delay slot.
REQ-012 bad_addr_i  input  32  faulting virtual address for codes 4/5.
REQ-013 data_o  output  32  MFC0 read data, combinational.
REQ-014 count_o, compare_o, status_o, cause_o, epc_o, badvaddr_o  output  32 each  register contents.
REQ-015 timer_int_o  output  1  timer interrupt pending.

Function
REQ-016 Registers implemented: BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14); any other raddr_i SHALL read 0 and any other waddr_i write SHALL be ignored.
REQ-017 Count: with COUNT_HALF=1, an internal tick bit toggles each cycle and Count increments by 1 when tick=1; 32-bit wrap 0xFFFF_FFFF->0 with no flag.
REQ-018 An MTC0 to Count SHALL load data_i and suppress that cycle's increment.
REQ-019 timer_int_o SHALL set on the cycle after Count==Compare with Compare!=0, stay set, and clear only on an MTC0 to Compare (or reset).
REQ-020 Cause[15:10] SHALL be sampled every cycle as {int_i[5]|timer_int_o, int_i[4:0]}; Cause[9:8] (soft IP) SHALL be written only via MTC0.
REQ-021 MTC0 to Status writes bits [15:8] and [1:0] only; other bits hold their values.
REQ-022 MTC0 to Cause writes bits [9:8] only; MTC0 to EPC and Compare write all 32 bits; BadVAddr is read-only.
REQ-023 On excepttype_i in {1,4,5,8,9,a,c} with Status.EXL=0: EPC <= current_inst_addr_i-4 and Cause[31] (BD) <= 1 if is_in_delayslot_i, else EPC <= current_inst_addr_i and BD <= 0.
REQ-024 On the same exceptions regardless of EXL: Status.EXL <= 1; Cause[6:2] <= 0x00/04/05/08/09/0a/0c for codes 1/4/5/8/9/a/c; for codes 4/5 BadVAddr <= bad_addr_i.
REQ-025 With Status.EXL=1 on entry, EPC and BD SHALL NOT be updated (nested exception).
REQ-026 On excepttype_i = 0xe (eret): Status.EXL <= 0; no other register changes.
REQ-027 Any other nonzero excepttype_i SHALL be ignored.
REQ-028 Simultaneous exception/eret and MTC0: the exception update wins; the MTC0 write is dropped entirely, including a Count load.
REQ-029 data_o SHALL bypass a same-cycle MTC0: when we_i=1 and waddr_i==raddr_i for a writable register, return the post-write masked value.
REQ-030 Count increment and timer compare continue during an exception cycle.

Reset
REQ-031 On rst=1 at a clock edge: Status <= 0x0040_0000 (BEV=1); Count, Compare, Cause, EPC, BadVAddr, tick and timer_int_o <= 0.
REQ-032 Reset asserted mid-operation SHALL override every simultaneous write, exception and increment in that cycle.

Verification
REQ-033 Release reset, idle 10 cycles -> Count=5, Status=0x0040_0000, timer_int_o=0.
REQ-034 MTC0 Compare=0x20, MTC0 Count=0x1E, wait 4 cycles -> timer_int_o=1 and Cause[15]=1; then MTC0 Compare=0x100 -> timer_int_o=0 next cycle.
REQ-035 excepttype_i=0x4, PC=0xBFC0_1004, delayslot=1, bad_addr_i=0x1233 -> EPC=0xBFC0_1000, BD=1, ExcCode=4, BadVAddr=0x1233, EXL=1.
REQ-036 With EXL=1, excepttype_i=0x8 at PC=0x8000_0040 -> EPC unchanged, ExcCode=8; then excepttype_i=0xe -> EXL=0.
REQ-037 Same cycle: we_i=1 to EPC with 0xDEAD_BEEF and excepttype_i=0xc at PC=0x100 with EXL=0 -> EPC=0x100.
REQ-038 MTC0 Status=0xFFFF_FFFF with raddr_i=12 -> data_o=0x0040_FF03 in the same cycle, and the registered value matches next cycle.

Source files
------------

// File: rtl/cp0_reg.sv
// MIPS coprocessor-0 register subset: BadVAddr, Count, Compare, Status, Cause, EPC.
// Handles MTC0/MFC0 access, the Count/Compare timer, and exception/eret state updates.
module cp0_reg #(
  parameter int COUNT_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [4:0]  raddr_i,
  input  logic [31:0] data_i,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  input  logic [31:0] bad_addr_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
  localparam logic [4:0]  ADDR_COUNT    = 5'd9;
  localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
  localparam logic [4:0]  ADDR_STATUS   = 5'd12;
  localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
  localparam logic [4:0]  ADDR_EPC      = 5'd14;

  localparam logic [31:0] STATUS_WMASK  = 32'h0000_FF03;
  localparam logic [31:0] CAUSE_WMASK   = 32'h0000_0300;
  localparam logic [31:0] STATUS_RESET  = 32'h0040_0000;
  localparam int          EXL_BIT       = 1;

  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic [31:0] r_status;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_badvaddr;
  logic        r_tick;
  logic        r_timer_int;

  logic        w_exc;
  logic [4:0]  w_exc_code;
  logic        w_eret;
  logic        w_wr;
  logic        w_count_inc;
  logic [31:0] w_status_wdata;
  logic [31:0] w_cause_wdata;
  logic [31:0] w_rdata;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_exc      = 1'b0;
    w_exc_code = 5'h00;
    case (excepttype_i)
      32'h0000_0001: begin w_exc = 1'b1; w_exc_code = 5'h00; end
      32'h0000_0004: begin w_exc = 1'b1; w_exc_code = 5'h04; end
      32'h0000_0005: begin w_exc = 1'b1; w_exc_code = 5'h05; end
      32'h0000_0008: begin w_exc = 1'b1; w_exc_code = 5'h08; end
      32'h0000_0009: begin w_exc = 1'b1; w_exc_code = 5'h09; end
      32'h0000_000A: begin w_exc = 1'b1; w_exc_code = 5'h0A; end
      32'h0000_000C: begin w_exc = 1'b1; w_exc_code = 5'h0C; end
      default:       ;
    endcase
  end

  // An exception or eret in the same cycle drops the MTC0 entirely.
  assign w_eret         = (excepttype_i == 32'h0000_000E);
  assign w_wr           = we_i & ~w_exc & ~w_eret;
  assign w_count_inc    = (COUNT_HALF != 0) ? r_tick : 1'b1;
  assign w_status_wdata = (r_status & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
  assign w_cause_wdata  = (r_cause & ~CAUSE_WMASK) | (data_i & CAUSE_WMASK);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 32'h0;
      r_compare   <= 32'h0;
      r_status    <= STATUS_RESET;
      r_cause     <= 32'h0;
      r_epc       <= 32'h0;
      r_badvaddr  <= 32'h0;
      r_tick      <= 1'b0;
      r_timer_int <= 1'b0;
    end else begin
      r_tick <= ~r_tick;

      if (w_wr && waddr_i == ADDR_COUNT)
        r_count <= data_i;
      else if (w_count_inc)
        r_count <= r_count + 32'd1;

      if (w_wr && waddr_i == ADDR_COMPARE)
        r_timer_int <= 1'b0;
      else if (r_compare != 32'h0 && r_count == r_compare)
        r_timer_int <= 1'b1;

      r_cause[15:10] <= {int_i[5] | r_timer_int, int_i[4:0]};

      if (w_exc) begin
        // A nested exception keeps the EPC/BD of the outermost one.
        if (!r_status[EXL_BIT]) begin
          r_epc       <= is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
          r_cause[31] <= is_in_delayslot_i;
        end
        r_status[EXL_BIT] <= 1'b1;
        r_cause[6:2]      <= w_exc_code;
        if (excepttype_i == 32'h0000_0004 || excepttype_i == 32'h0000_0005)
          r_badvaddr <= bad_addr_i;
      end else if (w_eret) begin
        r_status[EXL_BIT] <= 1'b0;
      end else if (w_wr) begin
        case (waddr_i)
          ADDR_COMPARE: r_compare    <= data_i;
          ADDR_STATUS:  r_status     <= w_status_wdata;
          ADDR_CAUSE:   r_cause[9:8] <= data_i[9:8];
          ADDR_EPC:     r_epc        <= data_i;
          default:      ;
        endcase
      end
    end
  end

  // Reads of a register being written this cycle return the value it will hold next cycle.
  always_comb begin
    w_rdata = 32'h0;
    case (raddr_i)
      ADDR_BADVADDR: w_rdata = r_badvaddr;
      ADDR_COUNT:    w_rdata = (we_i && waddr_i == raddr_i) ? data_i : r_count;
      ADDR_COMPARE:  w_rdata = (we_i && waddr_i == raddr_i) ? data_i : r_compare;
      ADDR_STATUS:   w_rdata = (we_i && waddr_i == raddr_i) ? w_status_wdata : r_status;
      ADDR_CAUSE:    w_rdata = (we_i && waddr_i == raddr_i) ? w_cause_wdata : r_cause;
      ADDR_EPC:      w_rdata = (we_i && waddr_i == raddr_i) ? data_i : r_epc;
      default:       w_rdata = 32'h0;
    endcase
  end

  assign data_o      = w_rdata;
  assign count_o     = r_count;
  assign compare_o   = r_compare;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign badvaddr_o  = r_badvaddr;
  assign timer_int_o = r_timer_int;

endmodule
